// File: rtl/conv_2d_stream_pkg.sv
// conv_pkg: shared defaults, state encoding and clog2 helper for the 2-D convolver
package conv_pkg;
  localparam int K_DEF = 3;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_COEFF_DEF = 8;
  localparam int NB_OUT_DEF = 8;
  localparam int SHIFT_DEF = 0;
  typedef enum logic [1:0] {KLOAD, FILL, RUN} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/conv_2d_stream_if.sv
// conv_2d_stream_if: column stream, kernel load and result bus of the 2-D convolver
interface conv_2d_stream_if import conv_pkg::*; #(
  parameter int K = K_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_COEFF = NB_COEFF_DEF,
  parameter int NB_OUT = NB_OUT_DEF
);
  logic i_load_knl;
  logic [K*NB_COEFF-1:0] i_coeff;
  logic i_valid;
  logic i_sol;
  logic [K*NB_DATA-1:0] i_data;
  logic o_knl_ready;
  logic o_valid;
  logic signed [NB_OUT-1:0] o_pixel;
  logic o_sat;
  modport master(output i_load_knl, i_coeff, i_valid, i_sol, i_data,
                 input o_knl_ready, o_valid, o_pixel, o_sat);
  modport slave(input i_load_knl, i_coeff, i_valid, i_sol, i_data,
                output o_knl_ready, o_valid, o_pixel, o_sat);
endinterface

// File: rtl/conv_2d_stream_sat_round.sv
// sat_round: round-half-up arithmetic right shift followed by signed saturation
module sat_round #(
  parameter int NB_IN = 20,
  parameter int NB_OUT = 8,
  parameter int SHIFT = 0
)(
  input  logic signed [NB_IN-1:0]  x,
  output logic signed [NB_OUT-1:0] y,
  output logic                     sat
);
  localparam int NB_W = NB_IN + 1;
  localparam logic signed [NB_W-1:0] HALF = NB_W'((2**SHIFT) / 2);
  localparam logic signed [NB_W-1:0] MAX = NB_W'(2**(NB_OUT-1) - 1);
  localparam logic signed [NB_W-1:0] MIN = ~MAX;
  logic signed [NB_W-1:0] r;
  logic hi, lo;
  always_comb begin
    r = (NB_W'(x) + HALF) >>> SHIFT;
    hi = r > MAX;
    lo = r < MIN;
    sat = hi | lo;
    y = hi ? MAX[NB_OUT-1:0] : lo ? MIN[NB_OUT-1:0] : r[NB_OUT-1:0];
  end
endmodule

// File: rtl/conv_2d_stream.sv
// conv_2d_stream: KxK signed convolution over a column-streamed window with runtime kernel load
module conv_2d_stream import conv_pkg::*; #(
  parameter int K = K_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_COEFF = NB_COEFF_DEF,
  parameter int NB_OUT = NB_OUT_DEF,
  parameter int SHIFT = SHIFT_DEF
)(
  input logic clk,
  input logic i_rst,
  conv_2d_stream_if.slave bus
);
  localparam int NB_PROD = NB_DATA + NB_COEFF;
  localparam int NB_ACC = NB_PROD + clog2(K*K);
  localparam int CW = clog2(K + 1);
  state_t state;
  logic [CW-1:0] knl_cnt, fill_cnt, fill_nxt;
  logic signed [NB_COEFF-1:0] knl [K][K];
  logic signed [NB_DATA-1:0] win [K][K];
  logic signed [NB_PROD-1:0] prod [K][K];
  logic signed [NB_ACC-1:0] sum, acc;
  logic signed [NB_OUT-1:0] pixel;
  logic accept, fire, last, sat, win_v, prod_v, acc_v;
  always_comb begin
    accept = bus.i_valid && !bus.i_load_knl && state != KLOAD;
    fill_nxt = bus.i_sol ? CW'(1) : fill_cnt == CW'(K) ? fill_cnt : fill_cnt + 1'b1;
    fire = accept && fill_nxt == CW'(K);
    last = knl_cnt == CW'(K - 1);
    sum = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        sum += NB_ACC'(prod[r][c]);
  end
  sat_round #(.NB_IN(NB_ACC), .NB_OUT(NB_OUT), .SHIFT(SHIFT)) u_sat (.x(acc), .y(pixel), .sat(sat));
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= FILL;
      knl_cnt <= '0;
      fill_cnt <= '0;
      win_v <= 1'b0;
      prod_v <= 1'b0;
      acc_v <= 1'b0;
      acc <= '0;
      bus.o_valid <= 1'b0;
      bus.o_pixel <= '0;
      bus.o_sat <= 1'b0;
      bus.o_knl_ready <= 1'b1;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          knl[r][c] <= (r == K/2 && c == K/2) ? NB_COEFF'(1) : '0;
          win[r][c] <= '0;
          prod[r][c] <= '0;
        end
    end else begin
      win_v <= fire;
      prod_v <= win_v;
      acc_v <= prod_v;
      bus.o_valid <= acc_v;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod[r][c] <= NB_PROD'(win[r][c]) * NB_PROD'(knl[r][c]);
      acc <= sum;
      if (acc_v) begin
        bus.o_pixel <= pixel;
        bus.o_sat <= sat;
      end
      if (bus.i_load_knl) begin
        // a kernel load kills every result still in flight
        for (int r = 0; r < K; r++)
          knl[r][knl_cnt] <= bus.i_coeff[r*NB_COEFF +: NB_COEFF];
        knl_cnt <= last ? '0 : knl_cnt + 1'b1;
        state <= last ? FILL : KLOAD;
        bus.o_knl_ready <= last;
        fill_cnt <= '0;
        win_v <= 1'b0;
        prod_v <= 1'b0;
        acc_v <= 1'b0;
        bus.o_valid <= 1'b0;
      end else if (accept) begin
        for (int r = 0; r < K; r++) begin
          win[r][0] <= bus.i_data[r*NB_DATA +: NB_DATA];
          for (int c = 1; c < K; c++)
            win[r][c] <= win[r][c-1];
        end
        fill_cnt <= fill_nxt;
        state <= fill_nxt == CW'(K) ? RUN : FILL;
      end
    end
  end
endmodule
